// File: rtl/adc_dma_burst_mem_if.sv
// AXI4 (full) bus bundle between the adc_dma burst master and the burst memory.
// The data path is fixed at 32 bits, so the strobe is 4 bits.
//   master modport : drives AW/W/AR channels and BREADY/RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY and the B/R channels
interface adc_dma_burst_mem_if #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ID_WIDTH-1:0]   awid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awvalid;
  logic                          awready;

  logic [31:0]                   wdata;
  logic [3:0]                    wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;

  logic [C_S_AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  logic [C_S_AXI_ID_WIDTH-1:0]   arid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arvalid;
  logic                          arready;

  logic [C_S_AXI_ID_WIDTH-1:0]   rid;
  logic [31:0]                   rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/adc_dma_burst_mem.sv
// adc_dma_burst_mem: AXI4 slave burst memory acting as the DMA sink.
// Accepts INCR write bursts into an on-chip word array and serves INCR read
// bursts from it, one transaction at a time. Non-INCR bursts or a beat size
// other than 4 bytes answer SLVERR without touching the array (reads return 0).
// Ports:
//   ACLK     - clock
//   ARESETN  - asynchronous active-low reset (array contents are kept)
//   s_axi    - adc_dma_burst_mem_if.slave, full AXI4 AW/W/B/AR/R channels
// Optional build macro ADC_DMA_MEM_RANGE_CHECK_EN: beats whose unwrapped byte
// address is at or beyond MEM_DEPTH_WORDS*4 are out of range; such writes are
// dropped with SLVERR and such reads return 32'hDEADBEEF with SLVERR. Without
// the macro the word index silently wraps modulo the array depth.
module adc_dma_burst_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS    = 256
) (
  input logic                 ACLK,
  input logic                 ARESETN,
  adc_dma_burst_mem_if.slave  s_axi
);
  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
`ifdef ADC_DMA_MEM_RANGE_CHECK_EN
  // Keep the full word address so out-of-range beats can be recognised.
  localparam int WA_W = C_S_AXI_ADDR_WIDTH - 2;
`else
  localparam int WA_W = IDX_W;
`endif

  typedef enum logic [2:0] {IDLE, WBURST, WRESP, RREAD, RBEAT} state_t;

  state_t                      state_q, state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [WA_W-1:0]             waddr_q, waddr_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  beat_q, beat_d;
  logic                        bad_q, bad_d;
  logic                        err_q, err_d;
  logic                        over_q, over_d;
  logic                        rerr_q, rerr_d;
  logic [31:0]                 rdata_q, rdata_d;

  logic [31:0]                 mem [MEM_DEPTH_WORDS];
  logic                        mem_we;
  logic [IDX_W-1:0]            idx;
  logic                        oor;
  logic                        unused_addr;

  // Byte-offset bits (and upper bits in the wrapping build) carry no meaning here.
  assign unused_addr = ^{s_axi.awaddr, s_axi.araddr};

  assign idx = waddr_q[IDX_W-1:0];
`ifdef ADC_DMA_MEM_RANGE_CHECK_EN
  assign oor = (waddr_q >= WA_W'(MEM_DEPTH_WORDS));
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    waddr_d = waddr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    bad_d   = bad_q;
    err_d   = err_q;
    over_d  = over_q;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.wready  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write has priority; a pending read is taken on a later IDLE visit.
        if (s_axi.awvalid) begin
          s_axi.awready = 1'b1;
          id_d    = s_axi.awid;
          waddr_d = s_axi.awaddr[WA_W+1:2];
          len_d   = s_axi.awlen;
          beat_d  = 8'd0;
          bad_d   = (s_axi.awburst != 2'b01) || (s_axi.awsize != 3'd2);
          err_d   = 1'b0;
          over_d  = 1'b0;
          state_d = WBURST;
        end else if (s_axi.arvalid) begin
          s_axi.arready = 1'b1;
          id_d    = s_axi.arid;
          waddr_d = s_axi.araddr[WA_W+1:2];
          len_d   = s_axi.arlen;
          beat_d  = 8'd0;
          bad_d   = (s_axi.arburst != 2'b01) || (s_axi.arsize != 3'd2);
          state_d = RREAD;
        end
      end
      WBURST: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid) begin
          // over_q: the announced length has been used up, keep draining to WLAST.
          mem_we = !bad_q && !over_q && !oor;
          if (oor) err_d = 1'b1;
          if (s_axi.wlast) begin
            if (over_q || (beat_q != len_q)) err_d = 1'b1;
            state_d = WRESP;
          end else if (!over_q && (beat_q == len_q)) begin
            err_d  = 1'b1;
            over_d = 1'b1;
          end
          beat_d  = beat_q + 8'd1;
          waddr_d = waddr_q + WA_W'(1);
        end
      end
      WRESP: begin
        if (s_axi.bready) state_d = IDLE;
      end
      RREAD: begin
        if (oor)        rdata_d = 32'hDEAD_BEEF;
        else if (bad_q) rdata_d = 32'h0;
        else            rdata_d = mem[idx];
        rerr_d  = bad_q || oor;
        state_d = RBEAT;
      end
      RBEAT: begin
        if (s_axi.rready) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            waddr_d = waddr_q + WA_W'(1);
            state_d = RREAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      id_q    <= '0;
      waddr_q <= '0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      over_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      waddr_q <= waddr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      over_q  <= over_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is intentionally not reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b]) mem[idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.bvalid = (state_q == WRESP);
  assign s_axi.bid    = id_q;
  assign s_axi.bresp  = ((state_q == WRESP) && (bad_q || err_q)) ? 2'b10 : 2'b00;
  assign s_axi.rvalid = (state_q == RBEAT);
  assign s_axi.rid    = id_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = ((state_q == RBEAT) && rerr_q) ? 2'b10 : 2'b00;
  assign s_axi.rlast  = (state_q == RBEAT) && (beat_q == len_q);
endmodule

// File: tb/tb_adc_dma_burst_mem.sv
module tb_adc_dma_burst_mem;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_dma_burst_mem_if #(.C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32)) bus ();

  adc_dma_burst_mem #(
    .C_S_AXI_ID_WIDTH(1), .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(bus.slave)
  );

  typedef struct {
    bit          is_b;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        last;
    logic        id;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wdat [512];
  logic [3:0]  wstb [512];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(string what);
    checks++;
    errors++;
    $display("FAIL timeout waiting for %s", what);
  endfunction

  // ---------------- reference model ----------------
  function automatic bit in_range(logic [31:0] addr, int i);
`ifdef ADC_DMA_MEM_RANGE_CHECK_EN
    return ((addr >> 2) + 32'(i)) < 32'(DEPTH);
`else
    return (addr[0] === addr[0]) || (i < 0);
`endif
  endfunction

  function automatic int word_of(logic [31:0] addr, int i);
    return int'(((addr >> 2) + 32'(i)) % 32'(DEPTH));
  endfunction

  function automatic void model_write(logic [31:0] addr, int len, int nbeats,
                                      logic [1:0] burst, logic [2:0] size, logic id);
    bit   bad;
    bit   err;
    exp_t e;
    bad = (burst != 2'b01) || (size != 3'd2);
    err = (nbeats != len + 1);
    for (int i = 0; i < nbeats; i++) begin
      if (!in_range(addr, i)) err = 1'b1;
      else if (!bad && i <= len)
        for (int b = 0; b < 4; b++)
          if (wstb[i][b]) ref_mem[word_of(addr, i)][8*b +: 8] = wdat[i][8*b +: 8];
    end
    e.is_b = 1'b1; e.resp = (bad || err) ? 2'b10 : 2'b00;
    e.data = 32'h0; e.last = 1'b0; e.id = id;
    exp_q.push_back(e);
  endfunction

  function automatic void model_read(logic [31:0] addr, int len,
                                     logic [1:0] burst, logic [2:0] size, logic id);
    bit   bad;
    exp_t e;
    bad = (burst != 2'b01) || (size != 3'd2);
    for (int i = 0; i <= len; i++) begin
      e.is_b = 1'b0; e.id = id; e.last = (i == len);
      if (!in_range(addr, i)) begin e.data = 32'hDEADBEEF; e.resp = 2'b10; end
      else if (bad)           begin e.data = 32'h0;        e.resp = 2'b10; end
      else begin e.data = ref_mem[word_of(addr, i)]; e.resp = 2'b00; end
      exp_q.push_back(e);
    end
  endfunction

  // ---------------- bus driver (callers sit just after a posedge) ----------------
  task automatic aw_phase(logic [31:0] addr, int len, logic [1:0] burst,
                          logic [2:0] size, logic id, bit also_ar);
    bit ok = 0;
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awburst = burst;
    bus.awsize = size; bus.awid = id; bus.awvalid = 1'b1;
    if (also_ar) bus.arvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.awready) begin
        ok = 1;
        if (also_ar) chk("arready_loses_to_aw", 32'(bus.arready), 32'd0);
      end
    end
    if (!ok) timeout("awready");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_phase(int nbeats);
    bit ok;
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.wdata = wdat[i]; bus.wstrb = wstb[i];
      bus.wlast = (i == nbeats - 1); bus.wvalid = 1'b1;
      ok = 0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        if (bus.wready) ok = 1;
      end
      if (!ok) begin timeout("wready"); break; end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_phase();
    bit ok = 0;
    int n;
    bus.bready = 1'b0;
    n = $urandom_range(0, 2);
    repeat (n) begin @(posedge clk); #1; end
    bus.bready = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.bvalid) ok = 1;
    end
    if (!ok) timeout("bvalid");
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic ar_phase(logic [31:0] addr, int len, logic [1:0] burst,
                          logic [2:0] size, logic id);
    bit ok = 0;
    bus.araddr = addr; bus.arlen = 8'(len); bus.arburst = burst;
    bus.arsize = size; bus.arid = id; bus.arvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.arready) ok = 1;
    end
    if (!ok) timeout("arready");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic r_phase(int len, int stall_beat, int stall_n);
    bit ok;
    for (int i = 0; i <= len; i++) begin
      ok = 0;
      if (i == stall_beat && stall_n > 0) begin
        bus.rready = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
          @(negedge clk);
          if (bus.rvalid) ok = 1;
        end
        if (!ok) begin timeout("rvalid"); break; end
        repeat (stall_n) begin @(posedge clk); #1; end
        ok = 0;
      end
      bus.rready = 1'b1;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        if (bus.rvalid) ok = 1;
      end
      if (!ok) begin timeout("rvalid"); break; end
      @(posedge clk); #1;
      bus.rready = 1'b0;
    end
    bus.rready = 1'b0;
  endtask

  task automatic do_write(logic [31:0] addr, int len, int nbeats,
                          logic [1:0] burst, logic id);
    model_write(addr, len, nbeats, burst, 3'd2, id);
    aw_phase(addr, len, burst, 3'd2, id, 1'b0);
    w_phase(nbeats);
    b_phase();
  endtask

  task automatic do_read(logic [31:0] addr, int len, logic [1:0] burst,
                         logic id, int stall_beat, int stall_n);
    model_read(addr, len, burst, 3'd2, id);
    ar_phase(addr, len, burst, 3'd2, id);
    r_phase(len, stall_beat, stall_n);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_q.size() == 0 || !exp_q[0].is_b) begin
          timeout("expected B entry (unexpected write response)");
        end else begin
          e = exp_q.pop_front();
          chk("bresp", 32'(bus.bresp), 32'(e.resp));
          chk("bid", 32'(bus.bid), 32'(e.id));
        end
      end
      if (bus.rvalid) begin
        if (exp_q.size() == 0 || exp_q[0].is_b) begin
          timeout("expected R entry (unexpected read beat)");
        end else begin
          // While stalled the head is only peeked: the beat must stay stable.
          if (bus.rready) e = exp_q.pop_front();
          else            e = exp_q[0];
          chk("rdata", bus.rdata, e.data);
          chk("rresp", 32'(bus.rresp), 32'(e.resp));
          chk("rlast", 32'(bus.rlast), 32'(e.last));
          chk("rid", 32'(bus.rid), 32'(e.id));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          len, nb, sb;
    logic [1:0]  bu;
    logic        id;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0;
    bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid,
                           bus.bresp, bus.rresp, bus.rlast, bus.bid, bus.rid}), 32'd0);
    chk("reset_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_ctrl", 32'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid}), 32'd0);
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(32'h0, DEPTH - 1, DEPTH, 2'b01, 1'b0);

    // 8-beat write then read back.
    for (int i = 0; i < 8; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    do_write(32'h0, 7, 8, 2'b01, 1'b1);
    do_read(32'h0, 7, 2'b01, 1'b1, -1, 0);

    // AW and AR together at 0x20: write first, read sees the new data.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hC0DE_0000 + 32'(i); wstb[i] = 4'hF; end
    bus.araddr = 32'h20; bus.arlen = 8'd3; bus.arburst = 2'b01; bus.arsize = 3'd2; bus.arid = 1'b1;
    model_write(32'h20, 3, 4, 2'b01, 3'd2, 1'b0);
    model_read(32'h20, 3, 2'b01, 3'd2, 1'b1);
    aw_phase(32'h20, 3, 2'b01, 3'd2, 1'b0, 1'b1);
    w_phase(4);
    @(negedge clk);
    chk("arready_during_b", 32'(bus.arready), 32'd0);
    chk("bvalid_after_wlast", 32'(bus.bvalid), 32'd1);
    @(posedge clk); #1;
    b_phase();
    ar_phase(32'h20, 3, 2'b01, 3'd2, 1'b1);
    r_phase(3, -1, 0);

    // RREADY held low for 3 cycles on beat 2.
    do_read(32'h0, 3, 2'b01, 1'b0, 2, 3);

    // Partial strobes: 0xAABBCCDD then 0x11223344 with strobe 0x5.
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
    do_write(32'h40, 0, 1, 2'b01, 1'b0);
    wdat[0] = 32'h11223344; wstb[0] = 4'h5;
    do_write(32'h40, 0, 1, 2'b01, 1'b0);
    chk("model_strobe_merge", ref_mem[16], 32'hAA22CC44);
    do_read(32'h40, 0, 2'b01, 1'b1, 0, 1);

    // Early WLAST, then a clean write, late WLAST, FIXED burst.
    for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(32'h80, 3, 3, 2'b01, 1'b0);
    do_write(32'h90, 3, 4, 2'b01, 1'b1);
    do_write(32'hA0, 1, 4, 2'b01, 1'b0);
    do_write(32'hB0, 2, 3, 2'b00, 1'b1);
    do_read(32'h80, 15, 2'b01, 1'b0, -1, 0);
    do_read(32'hB0, 1, 2'b10, 1'b1, -1, 0);

    // Beyond the array end: wraps, or out of range when checking is built in.
    do_read(32'h400, 0, 2'b01, 1'b0, -1, 0);
    do_read(32'h3F8, 3, 2'b01, 1'b1, -1, 0);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      a   = $urandom_range(0, 2 * DEPTH * 4 - 1);
      len = $urandom_range(0, 15);
      bu  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      id  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        nb = len + 1;
        if ($urandom_range(0, 7) == 0) nb = $urandom_range(1, len + 3);
        for (int i = 0; i < nb; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
        do_write(a, len, nb, bu, id);
      end else begin
        sb = $urandom_range(0, len);
        do_read(a, len, bu, id, sb, $urandom_range(0, 3));
      end
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
